muldiv_unit: RTL

//  Multi-cycle RV32M/RV64M execute unit beside the integer ALU in the EX stage.
//  - Decodes funct3 for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  - Computes iteratively, one bit per cycle.
//  - valid/ready handshake on input and output so the pipeline can stall EX while busy.

---
 rtl/muldiv_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [TAGW-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] rd_out,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]      op;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] hi, lo, opnd;
  logic [CW-1:0]   count;

  logic            accept;
  logic            is_div;
  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign accept = in_valid & in_ready;
  assign is_div = funct3[2];

  // which operands are treated as signed
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (funct3)
      3'b001: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'b010: begin sgn_a = 1'b1; end
      3'b100: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      default: begin sgn_a = 1'b0; sgn_b = 1'b0; end
    endcase
  end

  assign neg_a = sgn_a & src_a[XLEN-1];
  assign neg_b = sgn_b & src_b[XLEN-1];
  assign mag_a = neg_a ? -src_a : src_a;
  assign mag_b = neg_b ? -src_b : src_b;

  assign div_zero = is_div & (src_b == '0);
  assign div_ovf  = is_div & ~funct3[0]
                  & (src_a == {1'b1, {(XLEN-1){1'b0}}})
                  & (&src_b);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod, fprod_s;
  logic [XLEN-1:0]   fast_res;

  assign fprod   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fprod_s = (neg_a ^ neg_b) ? -fprod : fprod;
  assign fast_res = (funct3 == 3'b000) ? fprod_s[XLEN-1:0]
                                       : fprod_s[2*XLEN-1:XLEN];
  assign special  = div_zero | div_ovf | ~is_div;

  // early results: div corner cases and the whole multiply
  always_comb begin
    special_res = fast_res;
    if (div_zero)
      special_res = funct3[1] ? src_a : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : src_a;
  end
`else
  assign special = div_zero | div_ovf;

  // early results for divide-by-zero and signed overflow
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? src_a : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : src_a;
  end
`endif

  logic [XLEN:0]     sum;
  logic [XLEN:0]     sh, diff;
  logic              ge;
  logic [XLEN-1:0]   nhi, nlo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, quo, rem, calc_res;

  // one shift-add or restoring-subtract step
  always_comb begin
    sum  = {1'b0, hi} + ({1'b0, opnd} & {(XLEN+1){lo[0]}});
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, opnd};
    ge   = ~diff[XLEN];
    if (op[2]) begin
      nhi = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
      nlo = {lo[XLEN-2:0], ge};
    end else begin
      nhi = sum[XLEN:1];
      nlo = {sum[0], lo[XLEN-1:1]};
    end
  end

  // sign fix and result select after the last step
  always_comb begin
    prod     = {nhi, nlo};
    prod_s   = neg_q ? -prod : prod;
    mul_res  = (op == 3'b000) ? prod_s[XLEN-1:0]
                              : prod_s[2*XLEN-1:XLEN];
    quo      = neg_q ? -nlo : nlo;
    rem      = neg_r ? -nhi : nhi;
    calc_res = op[2] ? (op[1] ? rem : quo) : mul_res;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_n = special ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count == LAST) state_n = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // operand latch, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      count  <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op     <= funct3;
            rd_out <= rd_in;
            neg_q  <= neg_a ^ neg_b;
            neg_r  <= neg_a;
            count  <= '0;
            hi     <= '0;
            lo     <= is_div ? mag_a : mag_b;
            opnd   <= is_div ? mag_b : mag_a;
            if (special) result <= special_res;
          end
        end
        CALC: begin
          hi    <= nhi;
          lo    <= nlo;
          count <= count + 1'b1;
          if (count == LAST) result <= calc_res;
        end
        default: ;
      endcase
    end
  end

endmodule
